// File: rtl/ram_pkg.sv
// Shared constants for the multi-read, single-write RAM: controller state
// encodings and the write-lane count helper.
package ram_pkg;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   function automatic int lane_count(input int bw, input int lw);
      return bw / lw;
   endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// CLEAR/RUN controller: after reset it walks every address once so the
// storage array can be zeroed, then parks in RUN.
module ram_clear_ctrl
   import ram_pkg::*;
#(
   parameter int addr_width = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  gwe,
   output logic                  busy,
   output logic [addr_width-1:0] cnt
);

   logic [0:0] state;

   // Everything freezes while gwe is low, reset included.
   always_ff @(posedge clk) begin
      if (gwe) begin
         if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
         end else if (state == ST_CLEAR) begin
            if (&cnt) begin
               state <= ST_RUN;
               cnt   <= '0;
            end else begin
               cnt <= cnt + addr_width'(1);
            end
         end
      end
   end

   assign busy = (state == ST_CLEAR);

endmodule

// File: rtl/ram_nr1w.sv
// Parameterised RAM with num_rports read ports, one lane-masked write port,
// a self-clearing reset sequence and optional registered reads with forwarding.
module ram_nr1w
   import ram_pkg::*;
#(
   parameter int bit_width  = 16,
   parameter int addr_width = 3,
   parameter int num_rports = 2,
   parameter int lane_width = 8,
   parameter int reg_read   = 0,
   parameter int bypass     = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             gwe,
   input  logic [num_rports*addr_width-1:0] rsel,
   output logic [num_rports*bit_width-1:0]  rdata,
   input  logic [addr_width-1:0]            wsel,
   input  logic [bit_width-1:0]             wdata,
   input  logic                             we,
   input  logic [lane_count(bit_width, lane_width)-1:0] wmask,
   output logic                             clr_busy
);

   localparam int depth = 2**addr_width;
   localparam int lanes = lane_count(bit_width, lane_width);

   logic [bit_width-1:0]  mem [depth];
   logic [addr_width-1:0] clr_cnt;
   logic                  wr_en;

   function automatic logic [bit_width-1:0] merge_lanes(
      input logic [bit_width-1:0] old_word,
      input logic [bit_width-1:0] new_word,
      input logic [lanes-1:0]     mask
   );
      logic [bit_width-1:0] res;
      res = old_word;
      for (int k = 0; k < lanes; k++) begin
         if (mask[k]) res[k*lane_width +: lane_width] = new_word[k*lane_width +: lane_width];
      end
      return res;
   endfunction

   ram_clear_ctrl #(
      .addr_width(addr_width)
   ) u_ctrl (
      .clk  (clk),
      .rst  (rst),
      .gwe  (gwe),
      .busy (clr_busy),
      .cnt  (clr_cnt)
   );

   // Reset wins over a same-edge write; user writes are dropped while clearing.
   assign wr_en = we & ~rst & ~clr_busy;

   always_ff @(posedge clk) begin
      if (gwe) begin
         if (clr_busy) begin
            mem[clr_cnt] <= '0;
         end else if (wr_en) begin
            mem[wsel] <= merge_lanes(mem[wsel], wdata, wmask);
         end
      end
   end

   for (genvar p = 0; p < num_rports; p++) begin : g_rport
      logic [addr_width-1:0] rsel_p;
      logic [bit_width-1:0]  word;

      assign rsel_p = rsel[p*addr_width +: addr_width];
      assign word   = mem[rsel_p];

      if (reg_read == 0) begin : g_comb
         assign rdata[p*bit_width +: bit_width] = clr_busy ? '0 : word;
      end else begin : g_reg
         logic [bit_width-1:0] rd_next;
         logic [bit_width-1:0] rd_p1;

         // With forwarding, a colliding write is seen as the merged new word.
         always_comb begin
            rd_next = word;
            if (rst || clr_busy) begin
               rd_next = '0;
            end else if ((bypass != 0) && wr_en && (wsel == rsel_p)) begin
               rd_next = merge_lanes(word, wdata, wmask);
            end
         end

         // Read register, one edge of latency
         always_ff @(posedge clk) begin
            if (gwe) rd_p1 <= rd_next;
         end

         assign rdata[p*bit_width +: bit_width] = rd_p1;
      end
   end

endmodule

// File: tb/tb_ram_nr1w.sv
// Directed scoreboard bench: one combinational-read instance and two
// registered-read instances (forwarding on/off) share the same stimulus.
module tb_ram_nr1w;

   logic        clk;
   logic        rst;
   logic        gwe;
   logic [5:0]  rsel;
   logic [2:0]  wsel;
   logic [15:0] wdata;
   logic        we;
   logic [1:0]  wmask;
   logic [31:0] rd_c, rd_b, rd_n;
   logic        busy_c, busy_b, busy_n;

   int total = 0;
   int bad   = 0;
   int n;

   typedef struct {
      string       tag;
      int          sel;
      logic [15:0] exp;
   } sb_ent_t;

   sb_ent_t sb[$];

   ram_nr1w #(.reg_read(0), .bypass(1)) u_comb (
      .clk(clk), .rst(rst), .gwe(gwe), .rsel(rsel), .rdata(rd_c), .wsel(wsel),
      .wdata(wdata), .we(we), .wmask(wmask), .clr_busy(busy_c));

   ram_nr1w #(.reg_read(1), .bypass(1)) u_byp (
      .clk(clk), .rst(rst), .gwe(gwe), .rsel(rsel), .rdata(rd_b), .wsel(wsel),
      .wdata(wdata), .we(we), .wmask(wmask), .clr_busy(busy_b));

   ram_nr1w #(.reg_read(1), .bypass(0)) u_nob (
      .clk(clk), .rst(rst), .gwe(gwe), .rsel(rsel), .rdata(rd_n), .wsel(wsel),
      .wdata(wdata), .we(we), .wmask(wmask), .clr_busy(busy_n));

   always #5 clk = ~clk;

   function automatic logic [15:0] obs(input int sel);
      case (sel)
         0:       return rd_c[15:0];
         1:       return rd_c[31:16];
         2:       return rd_b[15:0];
         3:       return rd_b[31:16];
         4:       return rd_n[15:0];
         default: return rd_n[31:16];
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic push(input string tag, input int sel, input logic [15:0] e);
      sb_ent_t ent;
      ent.tag = tag;
      ent.sel = sel;
      ent.exp = e;
      sb.push_back(ent);
   endtask

   task automatic drain();
      sb_ent_t ent;
      while (sb.size() > 0) begin
         ent = sb.pop_front();
         chk(ent.tag, {16'h0, obs(ent.sel)}, {16'h0, ent.exp});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      clk = 0; rst = 1; gwe = 1; we = 0;
      rsel = '0; wsel = '0; wdata = '0; wmask = '0;

      // reset edge
      tick();
      rst = 0;
      chk("rst_busy_c", {31'h0, busy_c}, 1);
      chk("rst_busy_b", {31'h0, busy_b}, 1);
      chk("rst_busy_n", {31'h0, busy_n}, 1);
      push("rst_rd_b0", 2, 16'h0000);
      push("rst_rd_n1", 5, 16'h0000);
      drain();

      // clear sequence with write attempts that must be discarded
      we = 1; wsel = 3'd6; wdata = 16'hFFFF; wmask = 2'b11; rsel = {3'd6, 3'd6};
      n = 0;
      while (busy_c === 1'b1 && n < 20) begin
         chk("clr_rd_c0", {16'h0, rd_c[15:0]}, 32'h0);
         tick();
         n++;
      end
      chk("clr_len", n, 8);
      we = 0;
      for (int a = 0; a < 8; a++) begin
         rsel = {3'(a), 3'(a)};
         #1;
         push("clr_word_c0", 0, 16'h0000);
         push("clr_word_c1", 1, 16'h0000);
         drain();
      end

      // lane-masked writes over an all-ones word
      we = 1; wsel = 3'd3; wdata = 16'hFFFF; wmask = 2'b11;
      tick();
      wdata = 16'hA5C3; wmask = 2'b01;
      tick();
      we = 0; rsel = {3'd3, 3'd3};
      #1;
      push("mask_c0", 0, 16'hFFC3);
      push("mask_c1", 1, 16'hFFC3);
      drain();
      tick();
      push("mask_b0", 2, 16'hFFC3);
      push("mask_b1", 3, 16'hFFC3);
      push("mask_n0", 4, 16'hFFC3);
      push("mask_n1", 5, 16'hFFC3);
      drain();

      // empty mask leaves memory alone, upper lane alone changes upper byte
      we = 1; wdata = 16'h0000; wmask = 2'b00;
      tick();
      push("mask0_c0", 0, 16'hFFC3);
      drain();
      wdata = 16'h1200; wmask = 2'b10;
      tick();
      we = 0;
      push("upper_c1", 1, 16'h12C3);
      drain();

      // same-edge collision on port 0, port 1 reads an unrelated word
      rsel = {3'd3, 3'd5};
      we = 1; wsel = 3'd5; wdata = 16'h1234; wmask = 2'b11;
      push("byp_full_b0", 2, 16'h1234);
      push("nob_full_n0", 4, 16'h0000);
      push("byp_other_b1", 3, 16'h12C3);
      push("nob_other_n1", 5, 16'h12C3);
      tick();
      drain();
      wdata = 16'hABCD; wmask = 2'b10;
      push("byp_part_b0", 2, 16'hAB34);
      push("nob_part_n0", 4, 16'h1234);
      tick();
      drain();
      we = 0;
      push("after_wr_c0", 0, 16'hAB34);
      drain();
      tick();
      push("nob_late_n0", 4, 16'hAB34);
      drain();

      // gwe low freezes everything, reset and write included
      gwe = 0; rst = 1; we = 1; wsel = 3'd5; wdata = 16'h0000; wmask = 2'b11;
      rsel = {3'd0, 3'd0};
      tick();
      chk("gwe0_busy", {31'h0, busy_c}, 0);
      push("gwe0_hold_b0", 2, 16'hAB34);
      push("gwe0_hold_n0", 4, 16'hAB34);
      drain();
      rsel = {3'd3, 3'd5};
      #1;
      push("gwe0_mem_c0", 0, 16'hAB34);
      push("gwe0_mem_c1", 1, 16'h12C3);
      drain();
      gwe = 1; rst = 0; we = 0;

      // reset, then reset again part-way through the clear
      rst = 1;
      tick();
      rst = 0;
      chk("rst2_busy", {31'h0, busy_c}, 1);
      push("rst2_zero_c0", 0, 16'h0000);
      push("rst2_zero_b0", 2, 16'h0000);
      drain();
      we = 1; wsel = 3'd5; wdata = 16'hFFFF; wmask = 2'b11;
      repeat (4) tick();
      chk("mid_busy", {31'h0, busy_c}, 1);
      rst = 1;
      tick();
      rst = 0;
      n = 0;
      while (busy_c === 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("restart_len", n, 8);
      we = 0;
      tick();
      push("restart_c0", 0, 16'h0000);
      push("restart_c1", 1, 16'h0000);
      push("restart_b0", 2, 16'h0000);
      push("restart_n1", 5, 16'h0000);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
